// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side responder for CPU load/store requests. Serves 32-bit word
//   reads and writes over a req/ready handshake, inserting WAIT_CYCLES wait
//   states between acceptance and the one-cycle ready pulse. Replaces the
//   zero-latency data RAM so the core sees realistic memory latency.
//
//   Optional feature macro: DEBUG_PORT_EN
//     defined   -> adds dbg_addr/dbg_data, an asynchronous read-only view of
//                  the RAM for the switch/7-seg debug display.
//     undefined -> no debug ports, no extra logic.
//
//   The RAM has no reset. Simulators that zero-initialise storage will see it
//   start at 0; hardware contents are undefined until written.
//
// Ports
//   clk       in   1       rising-edge clock
//   rst_n     in   1       asynchronous active-low reset
//   req       in   1       request strobe, sampled only in IDLE
//   we        in   1       1 = write, 0 = read (latched with req)
//   addr      in   ADDR_W  word address (latched with req)
//   wdata     in   32      write data (latched with req)
//   dbg_addr  in   ADDR_W  debug read address       (DEBUG_PORT_EN only)
//   dbg_data  out  32      RAM[dbg_addr], 0 if OOR  (DEBUG_PORT_EN only)
//   rdata     out  32      read data, held until the next response
//   ready     out  1       one-cycle response pulse
//   err       out  1       out-of-range flag, pulses with ready
//   busy      out  1       high while in WAIT or RESP
//
// State | meaning
// IDLE  | waiting for req; inputs go straight to the RAM port
// WAIT  | counting down wait states on the latched request
// RESP  | ready/err high for one cycle, then back to IDLE

module data_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
`ifdef DEBUG_PORT_EN
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [31:0]       dbg_data,
`endif
    output logic [31:0]       rdata,
    output logic              ready,
    output logic              err,
    output logic              busy
);

    localparam int                MEM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
    localparam bit                NO_WAIT  = (WAIT_CYCLES == 0);
    localparam logic [3:0]        CNT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              lat_en;
    logic              commit;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0]       acc_wdata;
    logic              acc_in_range;

    logic [31:0]       mem [DEPTH];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lat_en    = 1'b0;
        commit    = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    lat_en = 1'b1;
                    if (NO_WAIT) begin
                        state_nxt = RESP;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                    commit    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // With zero wait states the RAM access happens on the accepting edge,
    // before the latch registers hold the request, so use the live inputs.
    always_comb begin
        if (state == IDLE) begin
            acc_we    = we;
            acc_addr  = addr;
            acc_wdata = wdata;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
        acc_in_range = ({1'b0, acc_addr} < DEPTH_W);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata   <= 32'd0;
            ready   <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (lat_en) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            ready <= commit;
            err   <= commit & ~acc_in_range;
            busy  <= (state_nxt != IDLE);
            if (commit && !acc_we) begin
                rdata <= acc_in_range ? mem[acc_addr[MEM_AW-1:0]] : 32'd0;
            end
        end
    end

    // rst_n gate keeps a held-in-reset zero-wait instance from writing.
    always_ff @(posedge clk) begin
        if (rst_n && commit && acc_we && acc_in_range) begin
            mem[acc_addr[MEM_AW-1:0]] <= acc_wdata;
        end
    end

`ifdef DEBUG_PORT_EN
    logic dbg_in_range;
    assign dbg_in_range = ({1'b0, dbg_addr} < DEPTH_W);
    assign dbg_data     = dbg_in_range ? mem[dbg_addr[MEM_AW-1:0]] : 32'd0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder.
//   u_a: ADDR_W=9, DEPTH=256, WAIT_CYCLES=2 (latency, out-of-range, back-to-back, reset abort)
//   u_b: ADDR_W=8, DEPTH=256, WAIT_CYCLES=0 (zero-wait latency and busy)
// Cycle 0 is the cycle in which req is presented; outputs are sampled on the
// falling edge of each following cycle.

module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        req_a, we_a, ready_a, err_a, busy_a;
    logic [8:0]  addr_a;
    logic [31:0] wdata_a, rdata_a;

    logic        req_b, we_b, ready_b, err_b, busy_b;
    logic [7:0]  addr_b;
    logic [31:0] wdata_b, rdata_b;

`ifdef DEBUG_PORT_EN
    logic [8:0]  dbg_addr_a;
    logic [31:0] dbg_data_a;
    logic [7:0]  dbg_addr_b;
    logic [31:0] dbg_data_b;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    data_mem_responder #(.ADDR_W(9), .DEPTH(256), .WAIT_CYCLES(2)) u_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
`ifdef DEBUG_PORT_EN
        .dbg_addr(dbg_addr_a), .dbg_data(dbg_data_a),
`endif
        .rdata(rdata_a), .ready(ready_a), .err(err_a), .busy(busy_a)
    );

    data_mem_responder #(.ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) u_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
`ifdef DEBUG_PORT_EN
        .dbg_addr(dbg_addr_b), .dbg_data(dbg_data_b),
`endif
        .rdata(rdata_b), .ready(ready_b), .err(err_b), .busy(busy_b)
    );

    // One transaction on u_a: first ready cycle, pulse count, rdata/err at the
    // first pulse, and a per-cycle busy mask (bit c-1 = cycle c).
    task automatic txn_a(input logic w, input logic [8:0] a, input logic [31:0] d,
                         output int rcyc, output int npulse, output logic [31:0] rd,
                         output logic e, output logic [7:0] bmask);
        @(negedge clk);
        req_a = 1'b1; we_a = w; addr_a = a; wdata_a = d;
        rcyc = -1; npulse = 0; rd = 32'hXXXX_XXXX; e = 1'bx; bmask = 8'd0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) req_a = 1'b0;
            bmask[c-1] = busy_a;
            if (ready_a) begin
                npulse++;
                if (rcyc < 0) begin
                    rcyc = c; rd = rdata_a; e = err_a;
                end
            end
        end
    endtask

    task automatic txn_b(input logic w, input logic [7:0] a, input logic [31:0] d,
                         output int rcyc, output int npulse, output logic [31:0] rd,
                         output logic e, output logic [7:0] bmask);
        @(negedge clk);
        req_b = 1'b1; we_b = w; addr_b = a; wdata_b = d;
        rcyc = -1; npulse = 0; rd = 32'hXXXX_XXXX; e = 1'bx; bmask = 8'd0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) req_b = 1'b0;
            bmask[c-1] = busy_b;
            if (ready_b) begin
                npulse++;
                if (rcyc < 0) begin
                    rcyc = c; rd = rdata_b; e = err_b;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_a = 0; we_a = 0; addr_a = '0; wdata_a = '0;
        req_b = 0; we_b = 0; addr_b = '0; wdata_b = '0;
`ifdef DEBUG_PORT_EN
        dbg_addr_a = '0; dbg_addr_b = '0;
`endif
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if ({ready_a, err_a, busy_a} !== 3'b000) begin n_bad++; $display("FAIL reset_flags_a got %b want 000", {ready_a, err_a, busy_a}); end
        n_cmp++; if (rdata_a !== 32'd0) begin n_bad++; $display("FAIL reset_rdata_a got %h want 0", rdata_a); end
        n_cmp++; if ({ready_b, err_b, busy_b} !== 3'b000) begin n_bad++; $display("FAIL reset_flags_b got %b want 000", {ready_b, err_b, busy_b}); end
        n_cmp++; if (rdata_b !== 32'd0) begin n_bad++; $display("FAIL reset_rdata_b got %h want 0", rdata_b); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        int rc, np; logic [31:0] rd; logic e; logic [7:0] bm;
        txn_a(1'b1, 9'd5, 32'hDEADBEEF, rc, np, rd, e, bm);
        n_cmp++; if (rc !== 3) begin n_bad++; $display("FAIL wr_latency got %0d want 3", rc); end
        n_cmp++; if (np !== 1) begin n_bad++; $display("FAIL wr_pulses got %0d want 1", np); end
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL wr_err got %b want 0", e); end
        n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL wr_rdata_held got %h want 0", rd); end
        n_cmp++; if (bm !== 8'b0000_0111) begin n_bad++; $display("FAIL wr_busy got %b want 00000111", bm); end
        txn_a(1'b0, 9'd5, 32'h0, rc, np, rd, e, bm);
        n_cmp++; if (rc !== 3) begin n_bad++; $display("FAIL rd_latency got %0d want 3", rc); end
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_data got %h want deadbeef", rd); end
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL rd_err got %b want 0", e); end
    endtask

    task automatic test_zero_wait();
        int rc, np; logic [31:0] rd; logic e; logic [7:0] bm;
        txn_b(1'b1, 8'd5, 32'hDEADBEEF, rc, np, rd, e, bm);
        n_cmp++; if (rc !== 1) begin n_bad++; $display("FAIL zw_wr_latency got %0d want 1", rc); end
        txn_b(1'b0, 8'd5, 32'h0, rc, np, rd, e, bm);
        n_cmp++; if (rc !== 1) begin n_bad++; $display("FAIL zw_rd_latency got %0d want 1", rc); end
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL zw_rd_data got %h want deadbeef", rd); end
        n_cmp++; if (bm !== 8'b0000_0001) begin n_bad++; $display("FAIL zw_busy got %b want 00000001", bm); end
        n_cmp++; if (np !== 1) begin n_bad++; $display("FAIL zw_pulses got %0d want 1", np); end
    endtask

    // Address 300 aliases to 44 in the low 8 bits, so mem[44] catches a
    // write that ignored the range check.
    task automatic test_out_of_range();
        int rc, np; logic [31:0] rd; logic e; logic [7:0] bm;
        txn_a(1'b1, 9'd44, 32'h4444_4444, rc, np, rd, e, bm);
        txn_a(1'b1, 9'd300, 32'h55, rc, np, rd, e, bm);
        n_cmp++; if (rc !== 3) begin n_bad++; $display("FAIL oor_wr_ready got %0d want 3", rc); end
        n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL oor_wr_err got %b want 1", e); end
        txn_a(1'b0, 9'd300, 32'h0, rc, np, rd, e, bm);
        n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL oor_rd_data got %h want 0", rd); end
        n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL oor_rd_err got %b want 1", e); end
        txn_a(1'b0, 9'd44, 32'h0, rc, np, rd, e, bm);
        n_cmp++; if (rd !== 32'h4444_4444) begin n_bad++; $display("FAIL oor_alias_mem44 got %h want 44444444", rd); end
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL oor_inrange_err got %b want 0", e); end
    endtask

    task automatic test_back_to_back();
        int np;
        logic [19:0] rmask;
        np = 0; rmask = '0;
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b0; addr_a = 9'd5;
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            if (ready_a) begin np++; rmask[c] = 1'b1; end
        end
        req_a = 1'b0;
        n_cmp++; if (np !== 5) begin n_bad++; $display("FAIL b2b_pulses got %0d want 5", np); end
        n_cmp++; if (rmask !== 20'h88888) begin n_bad++; $display("FAIL b2b_ready_cycles got %h want 88888", rmask); end
        n_cmp++; if (rdata_a !== 32'hDEADBEEF) begin n_bad++; $display("FAIL b2b_rdata got %h want deadbeef", rdata_a); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int rc, np, seen; logic [31:0] rd; logic e; logic [7:0] bm;
        txn_a(1'b1, 9'd7, 32'hA, rc, np, rd, e, bm);
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b1; addr_a = 9'd7; wdata_a = 32'h1234;
        @(negedge clk);
        req_a = 1'b0;
        n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL abort_in_wait busy got %b want 1", busy_a); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({ready_a, err_a, busy_a} !== 3'b000) begin n_bad++; $display("FAIL abort_flags got %b want 000", {ready_a, err_a, busy_a}); end
        n_cmp++; if (rdata_a !== 32'd0) begin n_bad++; $display("FAIL abort_rdata got %h want 0", rdata_a); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ready_a) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL abort_no_ready got %0d pulses want 0", seen); end
        txn_a(1'b0, 9'd7, 32'h0, rc, np, rd, e, bm);
        n_cmp++; if (rd !== 32'hA) begin n_bad++; $display("FAIL abort_mem7 got %h want 0000000a", rd); end
    endtask

`ifdef DEBUG_PORT_EN
    task automatic test_debug();
        dbg_addr_a = 9'd5; #1;
        n_cmp++; if (dbg_data_a !== 32'hDEADBEEF) begin n_bad++; $display("FAIL dbg_addr5 got %h want deadbeef", dbg_data_a); end
        dbg_addr_a = 9'd300; #1;
        n_cmp++; if (dbg_data_a !== 32'd0) begin n_bad++; $display("FAIL dbg_addr300 got %h want 0", dbg_data_a); end
        dbg_addr_a = 9'd44; #1;
        n_cmp++; if (dbg_data_a !== 32'h4444_4444) begin n_bad++; $display("FAIL dbg_addr44 got %h want 44444444", dbg_data_a); end
        dbg_addr_b = 8'd5; #1;
        n_cmp++; if (dbg_data_b !== 32'hDEADBEEF) begin n_bad++; $display("FAIL dbg_b_addr5 got %h want deadbeef", dbg_data_b); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_zero_wait();
        test_out_of_range();
        test_back_to_back();
`ifdef DEBUG_PORT_EN
        test_debug();
`endif
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
